// File: rtl/udma_hyper_trans_issue.sv
`default_nettype none
// ============================================================================
//  Module   : udma_hyper_trans_issue
//  Brief    : Queues transfer requests from two requesters and issues them
//             one at a time to a hyperbus controller. Reports per-requester
//             end-of-transfer pulses and completion counts.
//  Revision : 1.0 - initial release
// ============================================================================
module udma_hyper_trans_issue #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int SW    = 16
) (
  input  logic                sys_clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_id_i,
  input  logic [AW-1:0]       req_addr_i,
  input  logic [SW-1:0]       req_size_i,
  input  logic                req_rw_i,
  output logic                trans_valid_o,
  input  logic                trans_ready_i,
  output logic [AW-1:0]       trans_addr_o,
  output logic [SW-1:0]       trans_size_o,
  output logic                trans_rw_o,
  output logic                trans_id_o,
  input  logic                trans_done_i,
  output logic                running_trans_sys_o,
  output logic                proc_id_sys_o,
  output logic [1:0]          evt_eot_o,
  output logic [1:0][7:0]     done_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EOT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Request queue storage (data only, no reset needed: validity comes from count)
  logic [DEPTH-1:0] mem_id_q;
  logic [DEPTH-1:0] mem_rw_q;
  logic [AW-1:0]    mem_addr_q [DEPTH];
  logic [SW-1:0]    mem_size_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic          infl_q, infl_d;
  logic          trans_valid_q, trans_valid_d;
  logic [AW-1:0] trans_addr_q;
  logic [SW-1:0] trans_size_q;
  logic          trans_rw_q;
  logic          trans_id_q;
  logic          proc_id_q, proc_id_d;
  logic [1:0]    evt_q, evt_d;
  logic [1:0][7:0] done_cnt_q;

  logic          push, pop, empty;
  logic          next_head_id;

  assign empty       = (count_q == '0);
  assign req_ready_o = (count_q != FULL_CNT);
  assign push        = req_valid_i & req_ready_o;

  // Head of queue decides what happens next; at most one transfer in flight
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    infl_d  = infl_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (mem_size_q[rd_ptr_q] == '0) begin
            // Zero-length transfer completes without touching the bus
            pop     = 1'b1;
            infl_d  = mem_id_q[rd_ptr_q];
            state_d = ST_EOT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (trans_ready_i) begin
          pop     = 1'b1;
          infl_d  = mem_id_q[rd_ptr_q];
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (trans_done_i) state_d = ST_EOT;
      end
      ST_EOT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue bookkeeping and next values of the registered outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    // If the popped entry was the only one, the new head is the one being pushed
    if (count_q == (PW+1)'(pop)) next_head_id = req_id_i;
    else                         next_head_id = mem_id_q[rd_ptr_d];
    if ((state_d == ST_WAIT) || (state_d == ST_EOT)) proc_id_d = infl_d;
    else if (count_d != '0)                          proc_id_d = next_head_id;
    else                                             proc_id_d = 1'b0;
    trans_valid_d = (state_d == ST_ISSUE);
    evt_d         = (state_d == ST_EOT) ? {infl_d, ~infl_d} : 2'b00;
  end

  // Queue data write port
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem_id_q[wr_ptr_q]   <= req_id_i;
      mem_rw_q[wr_ptr_q]   <= req_rw_i;
      mem_addr_q[wr_ptr_q] <= req_addr_i;
      mem_size_q[wr_ptr_q] <= req_size_i;
    end
  end

  // State, queue control and registered outputs
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      infl_q        <= 1'b0;
      trans_valid_q <= 1'b0;
      trans_addr_q  <= '0;
      trans_size_q  <= '0;
      trans_rw_q    <= 1'b0;
      trans_id_q    <= 1'b0;
      proc_id_q     <= 1'b0;
      evt_q         <= 2'b00;
      done_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      infl_q        <= infl_d;
      trans_valid_q <= trans_valid_d;
      proc_id_q     <= proc_id_d;
      evt_q         <= evt_d;
      // Capture head fields on entry to ISSUE so they stay stable while offered
      if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
        trans_addr_q <= mem_addr_q[rd_ptr_q];
        trans_size_q <= mem_size_q[rd_ptr_q];
        trans_rw_q   <= mem_rw_q[rd_ptr_q];
        trans_id_q   <= mem_id_q[rd_ptr_q];
      end
      if (state_d == ST_EOT) begin
        done_cnt_q[infl_d] <= done_cnt_q[infl_d] + 8'd1;
      end
    end
  end

  assign trans_valid_o       = trans_valid_q;
  assign trans_addr_o        = trans_addr_q;
  assign trans_size_o        = trans_size_q;
  assign trans_rw_o          = trans_rw_q;
  assign trans_id_o          = trans_id_q;
  assign proc_id_sys_o       = proc_id_q;
  assign evt_eot_o           = evt_q;
  assign done_cnt_o          = done_cnt_q;
  assign running_trans_sys_o = (!empty) | (state_q != ST_IDLE);

endmodule
`default_nettype wire
